// File: rtl/isp_sw_pkg.sv
// Shared types and helpers for the ISP stream switch.
package isp_sw_pkg;

  localparam int DEFAULT_DATA_W = 24;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_WAIT_VS = 1'b1
  } sw_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/isp_button_debounce.sv
// Push-button synchroniser with optional debounce and a one-cycle rising-edge pulse.
// Debounce counter present only when ISP_SW_DEBOUNCE_EN is defined.
module isp_button_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_button,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_stable;
  logic r_rise;

`ifdef ISP_SW_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  // Down-counter runs only while the synced level differs from the accepted one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_cnt    <= CNT_LOAD;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= CNT_LOAD;
      end else if (r_cnt == '0) begin
        r_stable <= r_sync2;
        r_rise   <= r_sync2;
        r_cnt    <= CNT_LOAD;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (DEBOUNCE_CYC > 0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_sync1  <= i_button;
      r_sync2  <= r_sync1;
      r_stable <= r_sync2;
      r_rise   <= r_sync2 & ~r_stable;
    end
  end
`endif

  assign o_rise = r_rise;

endmodule

// File: rtl/isp_stream_switch.sv
// Frame-synchronous N-way video stream selector with push-button mode cycling.
// Define ISP_SW_DEBOUNCE_EN to enable the button debounce counter.
//
// state   | meaning
// RUN     | outputs follow mode_active, den passed through
// WAIT_VS | new mode committed, den held low until its frame start
module isp_stream_switch
  import isp_sw_pkg::*;
#(
  parameter int   NUM_SRC      = 4,
  parameter int   DATA_W       = DEFAULT_DATA_W,
  parameter logic VSYNC_POL    = 1'b1,
  parameter int   DEBOUNCE_CYC = 500000,
  parameter int   INIT_MODE    = 0,
  localparam int  MODE_W       = clog2_min1(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      button,
  input  logic [NUM_SRC-1:0]        in_vsync,
  input  logic [NUM_SRC-1:0]        in_hsync,
  input  logic [NUM_SRC-1:0]        in_den,
  input  logic [NUM_SRC*DATA_W-1:0] in_data,
  output logic                      out_vsync,
  output logic                      out_hsync,
  output logic                      out_den,
  output logic [DATA_W-1:0]         out_data,
  output logic [MODE_W-1:0]         mode_active,
  output logic [MODE_W-1:0]         mode_pending,
  output logic                      switching
);

  localparam logic [MODE_W-1:0] INIT_M = MODE_W'(INIT_MODE);
  localparam logic [MODE_W-1:0] LAST_M = MODE_W'(NUM_SRC - 1);

  sw_state_e           r_state;
  logic [MODE_W-1:0]   r_mode_active;
  logic [MODE_W-1:0]   r_mode_pending;
  logic [NUM_SRC-1:0]  r_vs_lvl_prev;
  logic                r_out_vsync;
  logic                r_out_hsync;
  logic                r_out_den;
  logic [DATA_W-1:0]   r_out_data;

  logic                w_press;
  logic [NUM_SRC-1:0]  w_vs_lvl;
  logic [NUM_SRC-1:0]  w_fs;
  logic                w_fs_act;
  logic                w_sel_vs;
  logic                w_sel_hs;
  logic                w_sel_den;
  logic [DATA_W-1:0]   w_sel_data;
  logic [MODE_W-1:0]   w_pending_inc;

  isp_button_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_button (button),
    .o_rise   (w_press)
  );

  // 1 where a stream sits at its active vsync level, independent of polarity.
  assign w_vs_lvl = in_vsync ^ {NUM_SRC{~VSYNC_POL}};
  assign w_fs     = w_vs_lvl & ~r_vs_lvl_prev;

  always_comb begin
    w_sel_vs   = 1'b0;
    w_sel_hs   = 1'b0;
    w_sel_den  = 1'b0;
    w_sel_data = '0;
    w_fs_act   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r_mode_active == MODE_W'(k)) begin
        w_sel_vs   = in_vsync[k];
        w_sel_hs   = in_hsync[k];
        w_sel_den  = in_den[k];
        w_sel_data = in_data[k*DATA_W +: DATA_W];
        w_fs_act   = w_fs[k];
      end
    end
  end

  assign w_pending_inc = (r_mode_pending == LAST_M) ? '0 : r_mode_pending + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_lvl_prev <= '0;
    end else begin
      r_vs_lvl_prev <= w_vs_lvl;
    end
  end

  // Commit reads the pending mode before this cycle's press lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_RUN;
      r_mode_active  <= INIT_M;
      r_mode_pending <= INIT_M;
      r_out_vsync    <= ~VSYNC_POL;
      r_out_hsync    <= 1'b0;
      r_out_den      <= 1'b0;
      r_out_data     <= '0;
    end else begin
      r_out_vsync <= w_sel_vs;
      r_out_hsync <= w_sel_hs;
      r_out_data  <= w_sel_data;
      if (w_press) begin
        r_mode_pending <= w_pending_inc;
      end
      case (r_state)
        ST_RUN: begin
          if (w_fs_act && (r_mode_pending != r_mode_active)) begin
            r_mode_active <= r_mode_pending;
            r_out_den     <= 1'b0;
            r_state       <= ST_WAIT_VS;
          end else begin
            r_out_den <= w_sel_den;
          end
        end
        ST_WAIT_VS: begin
          if (w_fs_act) begin
            r_out_den <= w_sel_den;
            r_state   <= ST_RUN;
          end else begin
            r_out_den <= 1'b0;
          end
        end
        default: begin
          r_out_den <= 1'b0;
          r_state   <= ST_RUN;
        end
      endcase
    end
  end

  assign out_vsync    = r_out_vsync;
  assign out_hsync    = r_out_hsync;
  assign out_den      = r_out_den;
  assign out_data     = r_out_data;
  assign mode_active  = r_mode_active;
  assign mode_pending = r_mode_pending;
  assign switching    = (r_state == ST_WAIT_VS);

endmodule

// File: tb/tb_isp_stream_switch.sv
// Self-checking bench for isp_stream_switch: directed scenarios plus random streams vs a frame-level model.
module tb_isp_stream_switch;

  localparam int   NS   = 4;
  localparam int   DW   = 24;
  localparam logic POL  = 1'b1;
  localparam int   INIT = 2;
  localparam int   DEB  = 16;
`ifdef ISP_SW_DEBOUNCE_EN
  localparam int   M_DEB = DEB;
`else
  localparam int   M_DEB = 1;
`endif

  logic             clk;
  logic             reset_n;
  logic             button;
  logic [NS-1:0]    in_vsync;
  logic [NS-1:0]    in_hsync;
  logic [NS-1:0]    in_den;
  logic [NS*DW-1:0] in_data;
  logic             out_vsync;
  logic             out_hsync;
  logic             out_den;
  logic [DW-1:0]    out_data;
  logic [1:0]       mode_active;
  logic [1:0]       mode_pending;
  logic             switching;

  isp_stream_switch #(
    .NUM_SRC      (NS),
    .DATA_W       (DW),
    .VSYNC_POL    (POL),
    .DEBOUNCE_CYC (DEB),
    .INIT_MODE    (INIT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .button       (button),
    .in_vsync     (in_vsync),
    .in_hsync     (in_hsync),
    .in_den       (in_den),
    .in_data      (in_data),
    .out_vsync    (out_vsync),
    .out_hsync    (out_hsync),
    .out_den      (out_den),
    .out_data     (out_data),
    .mode_active  (mode_active),
    .mode_pending (mode_pending),
    .switching    (switching)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: frame-level view of selected stream, modes and switch window.
  int            m_active, m_pending;
  bit            m_wait;
  logic          m_o_vs, m_o_hs, m_o_den;
  logic [DW-1:0] m_o_data;
  logic [NS-1:0] m_vs_prev;
  logic          m_hist0, m_hist1, m_acc, m_pulse;
  int            m_run;

  task automatic model_reset();
    m_active  = INIT;
    m_pending = INIT;
    m_wait    = 1'b0;
    m_o_vs    = ~POL;
    m_o_hs    = 1'b0;
    m_o_den   = 1'b0;
    m_o_data  = '0;
    m_vs_prev = {NS{~POL}};
    m_hist0   = 1'b0;
    m_hist1   = 1'b0;
    m_acc     = 1'b0;
    m_pulse   = 1'b0;
    m_run     = 0;
  endtask

  task automatic model_step();
    int sel;
    bit fs_act;
    logic s;
    sel      = m_active;
    fs_act   = (in_vsync[sel] == POL) && (m_vs_prev[sel] != POL);
    m_o_vs   = in_vsync[sel];
    m_o_hs   = in_hsync[sel];
    m_o_data = in_data[sel*DW +: DW];
    if (!m_wait) begin
      if (fs_act && (m_pending != m_active)) begin
        m_o_den  = 1'b0;
        m_active = m_pending;
        m_wait   = 1'b1;
      end else begin
        m_o_den = in_den[sel];
      end
    end else begin
      if (fs_act) begin
        m_wait  = 1'b0;
        m_o_den = in_den[sel];
      end else begin
        m_o_den = 1'b0;
      end
    end
    if (m_pulse) m_pending = (m_pending + 1) % NS;
    // Button: two-stage sync delay, then M_DEB consecutive differing samples accept a level.
    s       = m_hist1;
    m_pulse = 1'b0;
    if (s == m_acc) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == M_DEB) begin
        m_acc   = s;
        m_run   = 0;
        m_pulse = s;
      end
    end
    m_hist1   = m_hist0;
    m_hist0   = button;
    m_vs_prev = in_vsync;
  endtask

  task automatic check_model();
    check_eq("vsync", {31'd0, out_vsync}, {31'd0, m_o_vs});
    check_eq("hsync", {31'd0, out_hsync}, {31'd0, m_o_hs});
    check_eq("den", {31'd0, out_den}, {31'd0, m_o_den});
    check_eq("data", {8'd0, out_data}, {8'd0, m_o_data});
    check_eq("active", {30'd0, mode_active}, m_active);
    check_eq("pending", {30'd0, mode_pending}, m_pending);
    check_eq("switching", {31'd0, switching}, {31'd0, m_wait});
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic press();
    button = 1'b1;
    repeat (M_DEB + 4) cyc();
    button = 1'b0;
    repeat (M_DEB + 4) cyc();
  endtask

  task automatic frame_start(input int k);
    in_vsync[k] = POL;
    cyc();
    in_vsync[k] = ~POL;
    cyc();
  endtask

  task automatic const_streams();
    for (int k = 0; k < NS; k++) begin
      in_data[k*DW +: DW] = DW'(k * 32'h111111);
    end
    in_vsync = {NS{~POL}};
    in_hsync = '0;
    in_den   = '1;
  endtask

  initial begin
    reset_n = 1'b0;
    button  = 1'b0;
    const_streams();
    model_reset();

    // Reset values
    repeat (3) cyc();
    check_eq("t1_active", {30'd0, mode_active}, 32'd2);
    check_eq("t1_pending", {30'd0, mode_pending}, 32'd2);
    check_eq("t1_den", {31'd0, out_den}, 32'd0);
    check_eq("t1_vsync", {31'd0, out_vsync}, {31'd0, ~POL});
    check_eq("t1_switching", {31'd0, switching}, 32'd0);
    reset_n = 1'b1;
    repeat (4) cyc();

    // One press mid-frame, switch at next frame start of stream 2
    check_eq("t2_pre_data", {8'd0, out_data}, 32'h222222);
    press();
    check_eq("t2_hold_data", {8'd0, out_data}, 32'h222222);
    check_eq("t2_hold_active", {30'd0, mode_active}, 32'd2);
    check_eq("t2_pending", {30'd0, mode_pending}, 32'd3);
    in_vsync[2] = POL;
    cyc();
    check_eq("t2_edge_den", {31'd0, out_den}, 32'd0);
    check_eq("t2_edge_active", {30'd0, mode_active}, 32'd3);
    check_eq("t2_edge_sw", {31'd0, switching}, 32'd1);
    in_vsync[2] = ~POL;
    repeat (3) cyc();
    check_eq("t2_new_data", {8'd0, out_data}, 32'h333333);
    check_eq("t2_gap_den", {31'd0, out_den}, 32'd0);
    in_vsync[3] = POL;
    cyc();
    check_eq("t2_resume_den", {31'd0, out_den}, 32'd1);
    check_eq("t2_resume_sw", {31'd0, switching}, 32'd0);
    in_vsync[3] = ~POL;
    cyc();

    // Four presses in one frame wrap back to the active mode
    for (int i = 0; i < NS; i++) begin
      press();
      check_eq("t3_pending", {30'd0, mode_pending}, (3 + 1 + i) % NS);
    end
    in_vsync[3] = POL;
    cyc();
    check_eq("t3_no_gap_den", {31'd0, out_den}, 32'd1);
    check_eq("t3_no_switch", {31'd0, switching}, 32'd0);
    check_eq("t3_active", {30'd0, mode_active}, 32'd3);
    in_vsync[3] = ~POL;
    cyc();

`ifdef ISP_SW_DEBOUNCE_EN
    // Short pulses rejected, a long one counted once
    for (int p = 0; p < 2; p++) begin
      button = 1'b1;
      repeat (10) cyc();
      button = 1'b0;
      repeat (20) cyc();
    end
    check_eq("t4_short", {30'd0, mode_pending}, 32'd3);
    button = 1'b1;
    repeat (20) cyc();
    button = 1'b0;
    repeat (30) cyc();
    check_eq("t4_long", {30'd0, mode_pending}, 32'd0);
`endif

    // Reach active 0 / pending 1
    for (int i = 0; i < NS && m_pending != 0; i++) press();
    frame_start(3);
    frame_start(0);
    check_eq("t5_setup_active", {30'd0, mode_active}, 32'd0);
    check_eq("t5_setup_sw", {31'd0, switching}, 32'd0);
    press();
    check_eq("t5_setup_pend", {30'd0, mode_pending}, 32'd1);

    // Press pulse lands on the same cycle as stream 0's frame start
    button = 1'b1;
    repeat (M_DEB + 2) cyc();
    in_vsync[0] = POL;
    cyc();
    check_eq("t5_commit", {30'd0, mode_active}, 32'd1);
    check_eq("t5_pend_next", {30'd0, mode_pending}, 32'd2);
    check_eq("t5_sw", {31'd0, switching}, 32'd1);
    in_vsync[0] = ~POL;
    button = 1'b0;
    repeat (M_DEB + 4) cyc();

    // Reset in the middle of WAIT_VS
    check_eq("t6_in_wait", {31'd0, switching}, 32'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("t6_async_den", {31'd0, out_den}, 32'd0);
    check_eq("t6_async_sw", {31'd0, switching}, 32'd0);
    cyc();
    check_eq("t6_active", {30'd0, mode_active}, 32'd2);
    check_eq("t6_vsync", {31'd0, out_vsync}, {31'd0, ~POL});
    check_eq("t6_data", {8'd0, out_data}, 32'h0);
    reset_n = 1'b1;
    repeat (2) cyc();
    check_eq("t6_run_sw", {31'd0, switching}, 32'd0);
    check_eq("t6_run_active", {30'd0, mode_active}, 32'd2);
    check_eq("t6_run_den", {31'd0, out_den}, 32'd1);

    // Random streams and button against the model
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NS; k++) begin
        if ($urandom_range(0, 19) == 0) in_vsync[k] = ~in_vsync[k];
        in_data[k*DW +: DW] = DW'($urandom);
      end
      in_hsync = NS'($urandom);
      in_den   = NS'($urandom);
      if ($urandom_range(0, (M_DEB > 1) ? 40 : 7) == 0) button = ~button;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
